// File: rtl/bit_stream_serializer.sv
// Bit stream serializer: buffers parallel words of programmable length in a
// small FIFO and shifts each one out MSB-first as a (d, valid) serial stream.
// Downstream can stall the shifter; flush drops everything except words_sent.
module bit_stream_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    output logic             out_d,
    output logic             out_valid,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = LW + WIDTH;

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // FIFO storage: each entry is {effective length, data}
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LW-1:0]    bits_left_q, bits_left_d;
    logic [15:0]      words_sent_q, words_sent_d;
    logic             in_ready_q, in_ready_d;

    logic [LW-1:0]    in_len_eff;
    logic [EW-1:0]    head;
    logic [LW-1:0]    head_len;
    logic [WIDTH-1:0] head_data;
    logic             push;
    logic             pop;
    logic             shifting;
    logic             word_done;
    logic             mem_we;

    // Handshake, pop decision and next-state for FIFO, shifter and counters
    always_comb begin
        in_len_eff = (in_len == '0 || in_len > WIDTH_L) ? WIDTH_L : in_len;
        head       = mem_q[rd_ptr_q];
        head_len   = head[EW-1:WIDTH];
        head_data  = head[WIDTH-1:0];

        push      = in_valid && in_ready_q;
        shifting  = (state_q == ST_SHIFT) && !stall;
        word_done = shifting && (bits_left_q == LW'(1));
        // A pop either starts from IDLE or chains directly onto a completing word
        pop       = !stall && (count_q != '0) && ((state_q == ST_IDLE) || word_done);
        mem_we    = push && !rst && !flush;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        shreg_d      = shreg_q;
        bits_left_d  = bits_left_q;
        words_sent_d = words_sent_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (word_done) begin
            words_sent_d = words_sent_q + 16'd1;
        end

        if (pop) begin
            // Left-align the word so its MSB sits at the shift-out position
            shreg_d     = head_data << (WIDTH_L - head_len);
            bits_left_d = head_len;
            state_d     = ST_SHIFT;
        end else if (shifting) begin
            shreg_d     = shreg_q << 1;
            bits_left_d = bits_left_q - LW'(1);
            if (word_done) begin
                state_d = ST_IDLE;
            end
        end

        if (rst || flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            state_d     = ST_IDLE;
            shreg_d     = '0;
            bits_left_d = '0;
            // Flush keeps the statistics; only reset clears them
            words_sent_d = rst ? 16'd0 : words_sent_q;
        end

        // Ready follows the post-edge occupancy, so a pop while full reopens next cycle
        in_ready_d = (count_d != DEPTH_C);
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {in_len_eff, in_data};
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        count_q      <= count_d;
        state_q      <= state_d;
        shreg_q      <= shreg_d;
        bits_left_q  <= bits_left_d;
        words_sent_q <= words_sent_d;
        in_ready_q   <= in_ready_d;
    end

    // Output decode; out_d is forced low outside SHIFT
    always_comb begin
        in_ready   = in_ready_q;
        out_d      = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
        out_valid  = (state_q == ST_SHIFT) && !stall;
        busy       = (count_q != '0) || (state_q == ST_SHIFT);
        words_sent = words_sent_q;
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Testbench for bit_stream_serializer: scoreboard of expected serial bits,
// filled on each accepted push and drained by a monitor on out_valid cycles.
module tb_bit_stream_serializer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic [3:0]  in_len;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        out_d;
    logic        out_valid;
    logic        busy;
    logic [15:0] words_sent;

    int   n_tests;
    int   n_fail;
    int   valid_cnt;
    int   exp_sent;
    logic exp_q [$];

    bit_stream_serializer #(.WIDTH(8), .DEPTH(4), .LW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .out_d      (out_d),
        .out_valid  (out_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every valid serial bit must match the head of the scoreboard
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("extra_bit", 32'd1, 32'd0);
            end else begin
                check_eq("bit", {31'd0, out_d}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    // Present a word and hold it until accepted; leaves in_valid high
    task automatic push_word(input logic [7:0] d, input logic [3:0] l);
        int   eff;
        int   n;
        logic r;
        eff = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
        in_data  = d;
        in_len   = l;
        in_valid = 1'b1;
        n = 0;
        forever begin
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                check_eq("push_timeout", 32'd0, 32'd1);
                return;
            end
        end
        for (int i = eff - 1; i >= 0; i--) exp_q.push_back(d[i]);
        $display("[TB] push data=%02h len=%0d (%0d bits)", d, l, eff);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 300);
        if (busy !== 1'b0) check_eq("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_first_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 50);
        if (out_valid !== 1'b1) check_eq("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int run;
        int v0;
        n_tests = 0; n_fail = 0; valid_cnt = 0; exp_sent = 0;
        rst = 1'b1; in_data = '0; in_len = '0; in_valid = 1'b0;
        stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_d", {31'd0, out_d}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_sent", {16'd0, words_sent}, 32'd0);

        // Single 5-bit word: latency, run length, completion
        push_word(8'h15, 4'd5);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_valid", {31'd0, out_valid}, 32'd0);
        check_eq("lat_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("w1_run", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        exp_sent = 1;
        check_eq("w1_end_valid", {31'd0, out_valid}, 32'd0);
        check_eq("w1_end_busy", {31'd0, busy}, 32'd0);
        check_eq("w1_sent", {16'd0, words_sent}, exp_sent);

        // Back-to-back words are contiguous
        @(posedge clk); #1;
        push_word(8'hA5, 4'd8);
        push_word(8'h03, 4'd2);
        in_valid = 1'b0;
        wait_first_valid();
        run = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1) break;
            run++;
        end
        exp_sent += 2;
        check_eq("b2b_run", run, 32'd10);
        check_eq("b2b_sent", {16'd0, words_sent}, exp_sent);

        // Stall for 3 cycles after the 2nd bit
        @(posedge clk); #1;
        v0 = valid_cnt;
        push_word(8'h15, 4'd5);
        in_valid = 1'b0;
        wait_first_valid();
        @(posedge clk); #1;
        @(posedge clk); #1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_valid", {31'd0, out_valid}, 32'd0);
            check_eq("stall_d", {31'd0, out_d}, 32'd1);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        wait_idle();
        exp_sent += 1;
        check_eq("stall_count", valid_cnt - v0, 32'd5);
        check_eq("stall_sent", {16'd0, words_sent}, exp_sent);

        // Fill the FIFO while stalled; 5th word held by the producer
        @(posedge clk); #1;
        stall = 1'b1;
        push_word(8'h03, 4'd2);
        push_word(8'h05, 4'd3);
        push_word(8'h09, 4'd4);
        push_word(8'h1E, 4'd5);
        check_eq("full_ready", {31'd0, in_ready}, 32'd0);
        in_data = 8'h2A; in_len = 4'd6; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("full_hold_ready", {31'd0, in_ready}, 32'd0);
            check_eq("full_hold_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        push_word(8'h2A, 4'd6);
        in_valid = 1'b0;
        wait_idle();
        exp_sent += 5;
        check_eq("fill_sent", {16'd0, words_sent}, exp_sent);
        check_eq("fill_drained", exp_q.size(), 32'd0);

        // Flush during the 3rd bit with two words queued
        @(posedge clk); #1;
        push_word(8'hFF, 4'd8);
        push_word(8'h0F, 4'd4);
        push_word(8'h33, 4'd6);
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check_eq("fl_bit3", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
        check_eq("fl_busy", {31'd0, busy}, 32'd0);
        check_eq("fl_ready", {31'd0, in_ready}, 32'd1);
        check_eq("fl_sent", {16'd0, words_sent}, exp_sent);
        repeat (3) @(negedge clk);
        check_eq("fl_quiet", {31'd0, busy}, 32'd0);

        // Length 0 and out-of-range length both mean full width
        @(posedge clk); #1;
        push_word(8'h81, 4'd0);
        in_valid = 1'b0;
        wait_idle();
        exp_sent += 1;
        check_eq("len0_sent", {16'd0, words_sent}, exp_sent);
        @(posedge clk); #1;
        push_word(8'h3C, 4'd15);
        in_valid = 1'b0;
        wait_idle();
        exp_sent += 1;
        check_eq("len15_sent", {16'd0, words_sent}, exp_sent);

        // Reset mid-word
        @(posedge clk); #1;
        push_word(8'h81, 4'd0);
        in_valid = 1'b0;
        wait_first_valid();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_sent = 0;
        @(negedge clk);
        check_eq("mrst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_d", {31'd0, out_d}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_sent", {16'd0, words_sent}, exp_sent);

        check_eq("final_queue", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
